// File: rtl/alu_seq.sv
// Registered ALU with a persistent condition-code register.
// Single-cycle logic ops plus multi-cycle shift-add multiply and restoring divide.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       ccr,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MUL_RUN = 2'd1;
  localparam logic [1:0] DIV_RUN = 2'd2;

  localparam logic [3:0] OP_NOPA = 4'd0;
  localparam logic [3:0] OP_NOPB = 4'd1;
  localparam logic [3:0] OP_NOTA = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_CLRC = 4'd11;
  localparam logic [3:0] OP_SETC = 4'd12;

  localparam int M = WIDTH - 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             is_mod;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] res1;
  logic [3:0]       ccr1;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic             div0;
  logic [WIDTH-1:0] div_res;

  assign busy = (state != IDLE);

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};

  // Single-cycle result and flag update; multi-cycle ops are handled by the FSM.
  always_comb begin
    res1    = '0;
    ccr1    = ccr;
    unique case (op)
      OP_NOPA: res1 = a;
      OP_NOPB: res1 = b;
      OP_NOTA: res1 = ~a;
      OP_AND:  res1 = a & b;
      OP_OR:   res1 = a | b;
      OP_XOR:  res1 = a ^ b;
      OP_ADD: begin
        res1    = add_s[M:0];
        ccr1[0] = add_s[WIDTH];
        ccr1[1] = (a[M] == b[M]) && (add_s[M] != a[M]);
      end
      OP_SUB: begin
        res1    = sub_s[M:0];
        ccr1[0] = sub_s[WIDTH];
        ccr1[1] = (a[M] != b[M]) && (sub_s[M] != a[M]);
      end
      OP_CLRC: begin
        res1    = result;
        ccr1[0] = 1'b0;
      end
      OP_SETC: begin
        res1    = result;
        ccr1[0] = 1'b1;
      end
      default: res1 = '0;
    endcase
    if (op != OP_CLRC && op != OP_SETC) begin
      ccr1[2] = (res1 == '0);
      ccr1[3] = res1[M];
    end
  end

  // One shift-add step: add multiplicand if the multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_r[M:1]};
  end

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_sh   = {hi_r, lo_r[M]};
    div_diff = div_sh - {1'b0, b_r};
    div_ge   = (div_sh >= {1'b0, b_r});
    div_rem  = div_ge ? div_diff[M:0] : div_sh[M:0];
    div_quo  = {lo_r[M-1:0], div_ge};
    div0     = (b_r == '0);
    if (div0)
      div_res = is_mod ? a_r : '1;
    else
      div_res = is_mod ? div_rem : div_quo;
  end

  // Control FSM, operand/iteration registers and the architectural outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      is_mod <= 1'b0;
      result <= '0;
      ccr    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              state <= MUL_RUN;
              a_r   <= a;
              b_r   <= b;
              hi_r  <= '0;
              lo_r  <= b;
              cnt   <= CNT_W'(WIDTH);
            end else if (op == OP_DIV || op == OP_MOD) begin
              state  <= DIV_RUN;
              a_r    <= a;
              b_r    <= b;
              hi_r   <= '0;
              lo_r   <= a;
              is_mod <= (op == OP_MOD);
              cnt    <= CNT_W'(WIDTH);
            end else begin
              result <= res1;
              ccr    <= ccr1;
              done   <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          hi_r <= mul_hi;
          lo_r <= mul_lo;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            result <= mul_lo;
            ccr    <= {mul_lo[M], mul_lo == '0, mul_hi != '0, ccr[0]};
            done   <= 1'b1;
          end
        end
        DIV_RUN: begin
          hi_r <= div_rem;
          lo_r <= div_quo;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            result <= div_res;
            ccr    <= {div_res[M], div_res == '0, div0, ccr[0]};
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq.
// Inputs driven and outputs sampled on the falling edge.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic [3:0]  ccr;
  logic        busy;
  logic        done;

  int n_chk;
  int n_fail;
  int cyc;
  int bcyc;
  int dcnt;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .result(result), .ccr(ccr),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input logic [3:0] o,
                        input logic [15:0] x,
                        input logic [15:0] y,
                        output int c,
                        output int bc);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    bc = 0;
    while (!done && c < 40) begin
      if (busy) bc++;
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_ccr", {28'h0, ccr}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op(4'd12, 16'h0, 16'h0, cyc, bcyc);
    check("setc_pre", {28'h0, ccr}, 32'h1);
    start = 1'b1; op = 4'd8; a = 16'd3; b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmul_busy", {31'h0, busy}, 32'h0);
    check("rstmul_result", {16'h0, result}, 32'h0);
    check("rstmul_ccr", {28'h0, ccr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("rstmul_nodone", dcnt, 0);

    run_op(4'd6, 16'h7FFF, 16'h0001, cyc, bcyc);
    check("add1_lat", cyc, 1);
    check("add1_res", {16'h0, result}, 32'h8000);
    check("add1_ccr", {28'h0, ccr}, 32'hA);
    run_op(4'd6, 16'hFFFF, 16'h0001, cyc, bcyc);
    check("add2_res", {16'h0, result}, 32'h0);
    check("add2_ccr", {28'h0, ccr}, 32'h5);

    run_op(4'd7, 16'h0003, 16'h0005, cyc, bcyc);
    check("sub_res", {16'h0, result}, 32'hFFFE);
    check("sub_ccr", {28'h0, ccr}, 32'h9);
    run_op(4'd12, 16'h0, 16'h0, cyc, bcyc);
    check("setc_res", {16'h0, result}, 32'hFFFE);
    check("setc_ccr", {28'h0, ccr}, 32'h9);
    run_op(4'd11, 16'h0, 16'h0, cyc, bcyc);
    check("clrc_ccr", {28'h0, ccr}, 32'h8);
    run_op(4'd3, 16'h00F0, 16'h0F00, cyc, bcyc);
    check("and_res", {16'h0, result}, 32'h0);
    check("and_ccr", {28'h0, ccr}, 32'h4);

    run_op(4'd8, 16'h0100, 16'h0100, cyc, bcyc);
    check("mul1_lat", cyc, 17);
    check("mul1_busy", bcyc, 16);
    check("mul1_res", {16'h0, result}, 32'h0);
    check("mul1_ccr", {28'h0, ccr}, 32'h6);
    run_op(4'd8, 16'd7, 16'd9, cyc, bcyc);
    check("mul2_res", {16'h0, result}, 32'd63);
    check("mul2_ccr", {28'h0, ccr}, 32'h0);

    run_op(4'd9, 16'd100, 16'd7, cyc, bcyc);
    check("div_lat", cyc, 17);
    check("div_res", {16'h0, result}, 32'd14);
    run_op(4'd10, 16'd100, 16'd7, cyc, bcyc);
    check("mod_res", {16'h0, result}, 32'd2);
    check("mod_ccr", {28'h0, ccr}, 32'h0);
    run_op(4'd9, 16'd5, 16'd0, cyc, bcyc);
    check("div0_lat", cyc, 17);
    check("div0_res", {16'h0, result}, 32'hFFFF);
    check("div0_ccr", {28'h0, ccr}, 32'hA);
    run_op(4'd10, 16'd5, 16'd0, cyc, bcyc);
    check("mod0_res", {16'h0, result}, 32'd5);
    check("mod0_ccr", {28'h0, ccr}, 32'h2);

    run_op(4'd13, 16'h1234, 16'h5678, cyc, bcyc);
    check("rsv_res", {16'h0, result}, 32'h0);
    check("rsv_ccr", {28'h0, ccr}, 32'h6);

    start = 1'b1; op = 4'd9; a = 16'd100; b = 16'd7;
    dcnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      start = (i < 15);
      op = 4'd0;
      a = 16'hDEAD;
      b = 16'hBEEF;
    end
    check("storm_done", dcnt, 1);
    check("storm_res", {16'h0, result}, 32'd14);

    run_op(4'd9, 16'd9, 16'd3, cyc, bcyc);
    check("b2b_div", {16'h0, result}, 32'd3);
    run_op(4'd5, 16'hAAAA, 16'hFFFF, cyc, bcyc);
    check("b2b_lat", cyc, 1);
    check("b2b_res", {16'h0, result}, 32'h5555);
    check("b2b_ccr", {28'h0, ccr}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
